npc_ctrl: RTL and testbench
===========================

Name: npc_ctrl

Overview:
- Next-PC controller for the RV32I fetch stage.
- Sequences the branch-target path: immediate shifted left by one, added to the PC. It arbitrates that path against sequential PC+4, JAL, JALR and trap redirects.
- Holds a redirect when fetch back-pressures, and issues pipeline flush pulses.
- Sits between the ID/EX stages and the instruction-fetch interface.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- XLEN, 32, address/data width; only 32 supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_ready  in  1  fetch accepts pc this cycle.
- stall  in  1  pipeline stall; freezes sequential advance only.
- br_req  in  1  EX: conditional branch evaluated.
- br_taken  in  1  EX: branch condition true (qualified by br_req).
- jalr_req  in  1  EX: JALR resolved.
- ex_pc  in  32  PC of the EX instruction.
- ex_imm  in  32  sign-extended B/I immediate of the EX instruction; B-type holds offset>>1.
- rs1_val  in  32  JALR base.
- jal_req  in  1  ID: JAL decoded.
- id_pc  in  32  PC of the ID instruction.
- id_imm  in  32  sign-extended J immediate (offset>>1).
- trap_req  in  1  trap/exception redirect.
- trap_vec  in  32  trap target.
- pc  out  32  current fetch address.
- pc_valid  out  1  pc is presented to fetch.
- flush_id  out  1  one-cycle pulse: kill the IF/ID instruction.
- flush_ex  out  1  one-cycle pulse: kill the ID/EX instruction.
- misalign  out  1  one-cycle pulse: computed target[1] set; the redirect is suppressed.
- misalign_addr  out  32  the offending target, valid with misalign.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, pc_valid=0, flush_id=0, flush_ex=0, misalign=0, misalign_addr=0, state=BOOT, pending register cleared.
- FSM:
  - BOOT: the first clk after reset release sets pc_valid=1 and moves to RUN.
  - RUN: normal operation.
  - HOLD: a redirect was computed while if_ready=0. The target is held in the pending register. HOLD returns to RUN on the cycle if_ready=1.
- Target arithmetic, all modulo 2^32 with no overflow flag:
  - Branch target = ex_pc + {ex_imm[30:0],1'b0}.
  - JAL target = id_pc + {id_imm[30:0],1'b0}.
  - JALR target = (rs1_val + ex_imm) & ~32'h1.
  - Sequential = pc + 4.
- Priority, evaluated each cycle: trap_req > (br_req&br_taken | jalr_req) > jal_req > sequential. br_req and jalr_req are never both asserted; if they are, br_req wins.
- Misalignment: a branch/JAL/JALR target with bit1=1 pulses misalign with misalign_addr=target. pc does not change and no flush is issued. trap_vec is never checked.
- Redirect accept (RUN and if_ready=1): pc <= target on the next edge.
  - Trap or EX-level redirect: flush_id=1 and flush_ex=1 for one cycle.
  - JAL: flush_id=1 only.
- Redirect with if_ready=0: latch the target and its kind into pending, enter HOLD, pc unchanged.
- In HOLD:
  - A new trap_req overwrites pending; a lower-priority request is ignored.
  - When if_ready=1: pc <= pending, flush pulses per pending kind, return to RUN.
- Sequential advance: pc <= pc+4 when state=RUN, if_ready=1, stall=0 and no redirect. Wrap from 32'hFFFF_FFFC to 32'h0000_0000.
- Stall has no effect on redirects; redirects take effect even while stall=1.
- Flush pulses are never asserted two consecutive cycles for the same redirect.
- Reset mid-HOLD discards pending; no flush is emitted.

Decomposition:
- Shared package npc_pkg:
  - Redirect-kind enum: RK_NONE, RK_JAL, RK_EX, RK_TRAP.
  - FSM state enum: BOOT, RUN, HOLD.
  - RESET_PC default constant.
- Sub-module npc_target_gen (combinational): the three target adders, the shift-left-by-one of the immediates, the priority mux and the misalign detection. npc_ctrl keeps the FSM, pending register and pc register.

Test Plan:
- Reset release with if_ready=1 -> cycle 1 pc=0x0, pc_valid=1. Following cycles pc=0x4, then 0x8.
- Branch at ex_pc=0x100, ex_imm=0x8, br_taken=1, if_ready=1 -> next pc=0x110, flush_id=flush_ex=1 for exactly one cycle.
- Branch ex_pc=0x100, ex_imm=0xFFFFFFFE -> target 0xFC. Then jalr with rs1=0x201, ex_imm=0 -> pc=0x200.
- JAL id_pc=0x40, id_imm=0x1 -> target 0x42 -> misalign=1, misalign_addr=0x42, pc unchanged, no flush.
- Branch target 0x300 with if_ready=0 for 3 cycles, trap_req (trap_vec=0x80) in the 2nd cycle -> state HOLD, pc held. Once if_ready=1: pc=0x80, both flushes pulse once.
- pc=0xFFFFFFFC sequential -> pc=0x0. Then rst_n low mid-HOLD -> pc=RESET_PC immediately (async), flushes=0.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC controller.
//   redir_kind_e     : kind of redirect held in the pending register
//   BOOT/RUN/HOLD    : controller FSM state encodings
//   RESET_PC_DEFAULT : default first fetch address after reset
package npc_pkg;

  typedef enum logic [1:0] {
    RK_NONE,
    RK_JAL,
    RK_EX,
    RK_TRAP
  } redir_kind_e;

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/npc_target_gen.sv
// Combinational target generation and redirect arbitration.
// Inputs : current pc, EX branch/JALR operands, ID JAL operands, trap request/vector.
// Outputs: seq_pc_o (pc+4), kind_o / target_o (winning redirect, RK_NONE if none),
//          misalign_o (winning branch/JAL/JALR target has bit 1 set; traps never flagged).
module npc_target_gen
  import npc_pkg::*;
(
  input  logic [31:0]  pc_i,
  input  logic         br_req_i,
  input  logic         br_taken_i,
  input  logic         jalr_req_i,
  input  logic [31:0]  ex_pc_i,
  input  logic [31:0]  ex_imm_i,
  input  logic [31:0]  rs1_val_i,
  input  logic         jal_req_i,
  input  logic [31:0]  id_pc_i,
  input  logic [31:0]  id_imm_i,
  input  logic         trap_req_i,
  input  logic [31:0]  trap_vec_i,
  output logic [31:0]  seq_pc_o,
  output redir_kind_e  kind_o,
  output logic [31:0]  target_o,
  output logic         misalign_o
);

  logic [31:0] br_tgt;
  logic [31:0] jal_tgt;
  logic [31:0] jalr_tgt;

  // B/J immediates arrive as offset>>1; wrap-around addition is intended.
  assign br_tgt   = ex_pc_i + (ex_imm_i << 1);
  assign jal_tgt  = id_pc_i + (id_imm_i << 1);
  assign jalr_tgt = (rs1_val_i + ex_imm_i) & 32'hFFFF_FFFE;
  assign seq_pc_o = pc_i + 32'd4;

  always_comb begin
    kind_o   = RK_NONE;
    target_o = seq_pc_o;
    if (trap_req_i) begin
      kind_o   = RK_TRAP;
      target_o = trap_vec_i;
    end else if (br_req_i) begin
      // An asserted br_req masks jalr_req even when the branch is not taken.
      if (br_taken_i) begin
        kind_o   = RK_EX;
        target_o = br_tgt;
      end else if (jal_req_i) begin
        kind_o   = RK_JAL;
        target_o = jal_tgt;
      end
    end else if (jalr_req_i) begin
      kind_o   = RK_EX;
      target_o = jalr_tgt;
    end else if (jal_req_i) begin
      kind_o   = RK_JAL;
      target_o = jal_tgt;
    end
  end

  assign misalign_o = ((kind_o == RK_EX) || (kind_o == RK_JAL)) && target_o[1];

endmodule

// File: rtl/npc_ctrl.sv
// Next-PC controller for the RV32I fetch stage.
// Inputs : clk, rst_n, if_ready, stall, EX redirects (br_req/br_taken/jalr_req with
//          ex_pc/ex_imm/rs1_val), ID JAL (jal_req/id_pc/id_imm), trap_req/trap_vec.
// Outputs: pc/pc_valid to fetch, registered flush_id/flush_ex pulses,
//          misalign pulse with misalign_addr.
module npc_ctrl
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_ready,
  input  logic            stall,
  input  logic            br_req,
  input  logic            br_taken,
  input  logic            jalr_req,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            jal_req,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            flush_id,
  output logic            flush_ex,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic        flush_id_q, flush_id_d;
  logic        flush_ex_q, flush_ex_d;
  logic        misalign_q, misalign_d;
  logic [31:0] misalign_addr_q, misalign_addr_d;
  redir_kind_e pend_kind_q, pend_kind_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic [31:0] seq_pc;
  redir_kind_e sel_kind;
  logic [31:0] sel_target;
  logic        sel_misalign;

  npc_target_gen u_target_gen (
    .pc_i       (pc_q),
    .br_req_i   (br_req),
    .br_taken_i (br_taken),
    .jalr_req_i (jalr_req),
    .ex_pc_i    (ex_pc),
    .ex_imm_i   (ex_imm),
    .rs1_val_i  (rs1_val),
    .jal_req_i  (jal_req),
    .id_pc_i    (id_pc),
    .id_imm_i   (id_imm),
    .trap_req_i (trap_req),
    .trap_vec_i (trap_vec),
    .seq_pc_o   (seq_pc),
    .kind_o     (sel_kind),
    .target_o   (sel_target),
    .misalign_o (sel_misalign)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pc_valid_d      = pc_valid_q;
    flush_id_d      = 1'b0;
    flush_ex_d      = 1'b0;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    pend_kind_d     = pend_kind_q;
    pend_tgt_d      = pend_tgt_q;

    case (state_q)
      BOOT: begin
        pc_valid_d = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (sel_misalign) begin
          misalign_d      = 1'b1;
          misalign_addr_d = sel_target;
        end else if (sel_kind != RK_NONE) begin
          if (if_ready) begin
            pc_d       = sel_target;
            flush_id_d = 1'b1;
            flush_ex_d = (sel_kind != RK_JAL);
          end else begin
            pend_kind_d = sel_kind;
            pend_tgt_d  = sel_target;
            state_d     = HOLD;
          end
        end else if (if_ready && !stall) begin
          pc_d = seq_pc;
        end
      end
      HOLD: begin
        // Only a trap may replace the held redirect; it is taken at once if fetch is ready.
        if (sel_kind == RK_TRAP) begin
          pend_kind_d = RK_TRAP;
          pend_tgt_d  = sel_target;
        end
        if (if_ready) begin
          pc_d        = pend_tgt_d;
          flush_id_d  = 1'b1;
          flush_ex_d  = (pend_kind_d != RK_JAL);
          pend_kind_d = RK_NONE;
          state_d     = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= BOOT;
      pc_q            <= RESET_PC;
      pc_valid_q      <= 1'b0;
      flush_id_q      <= 1'b0;
      flush_ex_q      <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'h0;
      pend_kind_q     <= RK_NONE;
      pend_tgt_q      <= 32'h0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pc_valid_q      <= pc_valid_d;
      flush_id_q      <= flush_id_d;
      flush_ex_q      <= flush_ex_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
      pend_kind_q     <= pend_kind_d;
      pend_tgt_q      <= pend_tgt_d;
    end
  end

  assign pc            = pc_q;
  assign pc_valid      = pc_valid_q;
  assign flush_id      = flush_id_q;
  assign flush_ex      = flush_ex_q;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_npc_ctrl.sv
module tb_npc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_ready, stall, br_req, br_taken, jalr_req, jal_req, trap_req;
  logic [31:0] ex_pc, ex_imm, rs1_val, id_pc, id_imm, trap_vec;
  logic [31:0] pc, misalign_addr;
  logic        pc_valid, flush_id, flush_ex, misalign;

  int total = 0;
  int bad   = 0;

  npc_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_ready      (if_ready),
    .stall         (stall),
    .br_req        (br_req),
    .br_taken      (br_taken),
    .jalr_req      (jalr_req),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .rs1_val       (rs1_val),
    .jal_req       (jal_req),
    .id_pc         (id_pc),
    .id_imm        (id_imm),
    .trap_req      (trap_req),
    .trap_vec      (trap_vec),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .flush_id      (flush_id),
    .flush_ex      (flush_ex),
    .misalign      (misalign),
    .misalign_addr (misalign_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        trap, br, tk, jalr, jal, rdy, stl;
    logic [31:0] xpc, ximm, rs1, ipc, iimm, tv;
    logic [31:0] e_pc;
    logic        e_fid, e_fex, e_mis;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t tbl[15];

  // Behavioural reference state
  bit          m_booted, m_hold, m_pend_both, m_valid, m_fid, m_fex, m_mis;
  logic [31:0] m_pc, m_pend, m_maddr;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_ready = 1'b1; stall = 1'b0; br_req = 1'b0; br_taken = 1'b0; jalr_req = 1'b0;
    jal_req = 1'b0; trap_req = 1'b0; ex_pc = '0; ex_imm = '0; rs1_val = '0;
    id_pc = '0; id_imm = '0; trap_vec = '0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] e_pc, input bit e_fid,
                           input bit e_fex, input bit e_mis, input logic [31:0] e_maddr);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".flush_id"}, {31'b0, flush_id}, {31'b0, e_fid});
    check({tag, ".flush_ex"}, {31'b0, flush_ex}, {31'b0, e_fex});
    check({tag, ".misalign"}, {31'b0, misalign}, {31'b0, e_mis});
    if (e_mis) check({tag, ".misalign_addr"}, misalign_addr, e_maddr);
  endtask

  // Reference: derive next outputs from the current inputs using the redirect rules.
  task automatic model_step();
    logic [31:0] t;
    bit          have, checked, both;
    m_fid = 0; m_fex = 0; m_mis = 0;
    if (!m_booted) begin
      m_booted = 1; m_valid = 1;
    end else if (m_hold) begin
      if (trap_req) begin m_pend = trap_vec; m_pend_both = 1; end
      if (if_ready) begin
        m_pc = m_pend; m_fid = 1; m_fex = m_pend_both; m_hold = 0;
      end
    end else begin
      have = 0; checked = 1; both = 1; t = 0;
      if (trap_req) begin
        have = 1; checked = 0; t = trap_vec;
      end else if (br_req && br_taken) begin
        have = 1; t = ex_pc + ex_imm * 2;
      end else if (jalr_req && !br_req) begin
        have = 1; t = rs1_val + ex_imm; t = t - (t % 2);
      end else if (jal_req) begin
        have = 1; both = 0; t = id_pc + id_imm * 2;
      end
      if (have && checked && (t % 4) >= 2) begin
        m_mis = 1; m_maddr = t;
      end else if (have) begin
        if (if_ready) begin
          m_pc = t; m_fid = 1; m_fex = both;
        end else begin
          m_hold = 1; m_pend = t; m_pend_both = both;
        end
      end else if (if_ready && !stall) begin
        m_pc = m_pc + 4;
      end
    end
  endtask

  initial begin
    tbl[0]  = '{0,0,0,0,0,1,0, 0,0,0,0,0,0, 32'h4,0,0,0,0};
    tbl[1]  = '{0,0,0,0,0,1,0, 0,0,0,0,0,0, 32'h8,0,0,0,0};
    tbl[2]  = '{0,1,1,0,0,1,0, 32'h100,32'h8,0,0,0,0, 32'h110,1,1,0,0};
    tbl[3]  = '{0,0,0,0,0,1,0, 0,0,0,0,0,0, 32'h114,0,0,0,0};
    tbl[4]  = '{0,1,1,0,0,1,0, 32'h100,32'hFFFF_FFFE,0,0,0,0, 32'hFC,1,1,0,0};
    tbl[5]  = '{0,0,0,1,0,1,0, 0,0,32'h201,0,0,0, 32'h200,1,1,0,0};
    tbl[6]  = '{0,0,0,0,1,1,0, 0,0,0,32'h40,32'h1,0, 32'h200,0,0,1,32'h42};
    tbl[7]  = '{0,0,0,0,0,1,1, 0,0,0,0,0,0, 32'h200,0,0,0,0};
    tbl[8]  = '{0,0,0,0,1,1,1, 0,0,0,32'h40,32'h10,0, 32'h60,1,0,0,0};
    tbl[9]  = '{0,0,0,0,0,0,0, 0,0,0,0,0,0, 32'h60,0,0,0,0};
    tbl[10] = '{0,1,0,0,0,1,0, 32'h100,32'h8,0,0,0,0, 32'h64,0,0,0,0};
    tbl[11] = '{1,0,0,0,0,1,0, 0,0,0,0,0,32'hFFFF_FFFC, 32'hFFFF_FFFC,1,1,0,0};
    tbl[12] = '{0,0,0,0,0,1,0, 0,0,0,0,0,0, 32'h0,0,0,0,0};
    tbl[13] = '{0,0,0,1,0,1,0, 0,32'h3,32'h100,0,0,0, 32'h0,0,0,1,32'h102};
    tbl[14] = '{0,0,0,0,0,1,0, 0,0,0,0,0,0, 32'h4,0,0,0,0};

    idle_inputs();
    #12;
    check_out("reset", 32'h0, 0, 0, 0, 0);
    check("reset.pc_valid", {31'b0, pc_valid}, 32'h0);
    check("reset.misalign_addr", misalign_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_out("boot", 32'h0, 0, 0, 0, 0);
    check("boot.pc_valid", {31'b0, pc_valid}, 32'h1);

    foreach (tbl[i]) begin
      trap_req = tbl[i].trap; br_req = tbl[i].br; br_taken = tbl[i].tk;
      jalr_req = tbl[i].jalr; jal_req = tbl[i].jal; if_ready = tbl[i].rdy;
      stall = tbl[i].stl; ex_pc = tbl[i].xpc; ex_imm = tbl[i].ximm; rs1_val = tbl[i].rs1;
      id_pc = tbl[i].ipc; id_imm = tbl[i].iimm; trap_vec = tbl[i].tv;
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_fid, tbl[i].e_fex,
                tbl[i].e_mis, tbl[i].e_maddr);
    end

    // Held branch overtaken by a trap while fetch is busy (pc is 0x4 here).
    idle_inputs();
    if_ready = 0; br_req = 1; br_taken = 1; ex_pc = 32'h200; ex_imm = 32'h80;
    tick(); check_out("hold1", 32'h4, 0, 0, 0, 0);
    idle_inputs(); if_ready = 0; trap_req = 1; trap_vec = 32'h80;
    tick(); check_out("hold2", 32'h4, 0, 0, 0, 0);
    idle_inputs(); if_ready = 0;
    tick(); check_out("hold3", 32'h4, 0, 0, 0, 0);
    if_ready = 1;
    tick(); check_out("hold_exit", 32'h80, 1, 1, 0, 0);
    tick(); check_out("hold_after", 32'h84, 0, 0, 0, 0);

    // Asynchronous reset while a redirect is pending.
    if_ready = 0; br_req = 1; br_taken = 1; ex_pc = 32'h200; ex_imm = 32'h80;
    tick(); check_out("rhold", 32'h84, 0, 0, 0, 0);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check_out("async_rst", 32'h0, 0, 0, 0, 0);
    check("async_rst.pc_valid", {31'b0, pc_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); check_out("reboot", 32'h0, 0, 0, 0, 0);
    tick(); check_out("reboot_seq", 32'h4, 0, 0, 0, 0);

    // Randomized run against the reference model.
    rst_n = 1'b0;
    #3;
    m_booted = 0; m_hold = 0; m_valid = 0; m_pc = 32'h0; m_pend = 0; m_pend_both = 0;
    m_maddr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if_ready = ($urandom_range(3) != 0);
      stall    = ($urandom_range(3) == 0);
      trap_req = ($urandom_range(15) == 0);
      br_req   = ($urandom_range(5) == 0);
      br_taken = $urandom_range(1);
      jalr_req = !br_req && ($urandom_range(6) == 0);
      jal_req  = ($urandom_range(5) == 0);
      ex_pc    = $urandom & 32'hFFFF_FFFC;
      ex_imm   = $urandom;
      rs1_val  = $urandom;
      id_pc    = $urandom & 32'hFFFF_FFFC;
      id_imm   = $urandom;
      trap_vec = $urandom & 32'hFFFF_FFFC;
      model_step();
      tick();
      check_out($sformatf("rnd%0d", n), m_pc, m_fid, m_fex, m_mis, m_maddr);
      check($sformatf("rnd%0d.pc_valid", n), {31'b0, pc_valid}, {31'b0, m_valid});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
